busybeaver_spi_readout: RTL and testbench



---
 rtl/busybeaver_spi_readout_pkg.sv | 30 +++
 rtl/busybeaver_spi_readout_if.sv | 14 +
 rtl/busybeaver_spi_readout_sync_edge.sv | 35 +++
 rtl/busybeaver_spi_readout.sv | 172 +++++++++++++++++
 tb/tb_busybeaver_spi_readout.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/busybeaver_spi_readout_pkg.sv
// busybeaver_pkg: command codes, status version, FSM states and the CRC-8 helper
// shared by the busy-beaver SPI readout block.
`default_nettype none

package busybeaver_pkg;

  localparam logic [7:0] CMD_READ_COUNT  = 8'h0B;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;
  localparam logic [7:0] CMD_RESTART     = 8'hA5;
  localparam logic [5:0] STATUS_VERSION  = 6'h01;
  localparam logic [7:0] CRC_POLY        = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_STAT = 3'd3,
    ST_ARM  = 3'd4,
    ST_DONE = 3'd5,
    ST_CRC  = 3'd6
  } bb_state_t;

  // One bit of a non-reflected CRC-8, data MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/busybeaver_spi_readout_if.sv
// busybeaver_spi_readout_if: the four SPI pins between host (master) and readout target (slave).
`default_nettype none

interface busybeaver_spi_readout_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

`default_nettype wire

// File: rtl/busybeaver_spi_readout_sync_edge.sv
// spi_sync_edge: multi-stage synchroniser for one SPI pin with single-cycle
// rise/fall pulses generated on the synchronised value.
`default_nettype none

module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;
  logic              sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

`default_nettype wire

// File: rtl/busybeaver_spi_readout.sv
// busybeaver_spi_readout: SPI mode-0 target returning the engine count/halt and issuing restarts.
// Optional macro BB_READOUT_CRC_EN appends a CRC-8 byte after READ_COUNT data.
`default_nettype none

module busybeaver_spi_readout
  import busybeaver_pkg::*;
#(
  parameter int COUNT_W        = 64,
  parameter int SYNC_STAGES    = 2,
  parameter int RESTART_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COUNT_W-1:0]   bb_count,
  input  logic                 bb_halt,
  output logic                 bb_rst_n,
  busybeaver_spi_readout_if.slave spi
);
  localparam int CNT_W = $clog2(COUNT_W + 1);
  localparam int RST_W = $clog2(RESTART_CYCLES + 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(COUNT_W - 1);

  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;
  bb_state_t              state;
  logic [7:0]             cmd;
  logic [7:0]             cmd_next;
  logic [COUNT_W-1:0]     snap;
  logic [COUNT_W-1:0]     tx_sh;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   miso_q;
  logic [RST_W-1:0]       rst_cnt;
  logic                   restart_busy;
  logic                   restart_commit;
  logic [7:0]             status;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi.sclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(spi.cs_n), .rise(cs_rise), .fall(cs_fall));

  // Same depth as the SCLK chain so MOSI is sampled alongside the detected rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign restart_busy   = (rst_cnt != '0);
  assign status         = {bb_halt, restart_busy, STATUS_VERSION};
  assign cmd_next       = {cmd[6:0], mosi_s};
  assign restart_commit = (state == ST_ARM) && cs_rise && !sclk_rise;
  assign spi.miso       = miso_q;

`ifdef BB_READOUT_CRC_EN
  logic [7:0] crc_val;
  always_comb begin
    crc_val = 8'h00;
    for (int i = COUNT_W - 1; i >= 0; i--) crc_val = crc8_step(crc_val, snap[i]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cmd     <= '0;
      snap    <= '0;
      tx_sh   <= '0;
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else if (cs_rise) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else begin
      if (sclk_fall && (state == ST_CMD || state == ST_DATA || state == ST_STAT || state == ST_CRC)) begin
        miso_q <= tx_sh[COUNT_W-1];
        tx_sh  <= tx_sh << 1;
      end
      case (state)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            snap    <= bb_count;
            tx_sh   <= COUNT_W'(status) << (COUNT_W - 7);
            miso_q  <= status[7];
            cmd     <= '0;
            bit_cnt <= '0;
            state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cmd     <= cmd_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt <= '0;
              case (cmd_next)
                CMD_READ_COUNT: begin
                  tx_sh <= snap;
                  state <= ST_DATA;
                end
                CMD_READ_STATUS: begin
                  tx_sh <= COUNT_W'(status) << (COUNT_W - 8);
                  state <= ST_STAT;
                end
                CMD_RESTART: state <= ST_ARM;
                default:     state <= ST_DONE;
              endcase
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef BB_READOUT_CRC_EN
              tx_sh <= COUNT_W'(crc_val) << (COUNT_W - 8);
              state <= ST_CRC;
`else
              state <= ST_DONE;
`endif
            end
          end
        end
        ST_STAT: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt <= '0;
              tx_sh   <= COUNT_W'(status) << (COUNT_W - 8);
            end
          end
        end
        ST_CRC: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == BYTE_LAST) state <= ST_DONE;
          end
        end
        ST_ARM: begin
          miso_q <= 1'b0;
          if (sclk_rise) state <= ST_DONE;
        end
        ST_DONE: miso_q <= 1'b0;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // bb_rst_n is low from the commit edge through RESTART_CYCLES clk; a new commit reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt  <= '0;
      bb_rst_n <= 1'b0;
    end else if (restart_commit) begin
      rst_cnt  <= RST_W'(RESTART_CYCLES);
      bb_rst_n <= 1'b0;
    end else if (rst_cnt != '0) begin
      rst_cnt  <= rst_cnt - RST_W'(1);
      bb_rst_n <= (rst_cnt == RST_W'(1));
    end else begin
      bb_rst_n <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_busybeaver_spi_readout.sv
// tb_busybeaver_spi_readout: table vectors, random frames against a reference model,
// plus restart, abort and snapshot-coherence sequences.
`default_nettype none

module tb_busybeaver_spi_readout;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] bb_count;
  logic [63:0] count_base = 64'h0;
  logic [63:0] inc_cnt = 64'h0;
  logic        inc_en = 1'b0;
  logic        bb_halt = 1'b0;
  logic        bb_rst_n;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] cnt_at_fall;

  logic        mon_en = 1'b0;
  int          low_run = 0;
  int          last_width = 0;
  int          pulses = 0;

  busybeaver_spi_readout_if spi_if ();

  busybeaver_spi_readout #(.COUNT_W(64), .SYNC_STAGES(2), .RESTART_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bb_count(bb_count), .bb_halt(bb_halt),
    .bb_rst_n(bb_rst_n), .spi(spi_if));

  always #5 clk = ~clk;

  always @(negedge clk) inc_cnt <= inc_en ? inc_cnt + 64'd1 : count_base;
  assign bb_count = inc_en ? inc_cnt : count_base;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!bb_rst_n) low_run <= low_run + 1;
      else if (low_run != 0) begin
        last_width <= low_run;
        pulses     <= pulses + 1;
        low_run    <= 0;
      end
    end
  end

  // CRC-8 as the remainder of {data, 8'h00} divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [63:0] d);
    logic [71:0] v;
    v = {d, 8'h00};
    for (int i = 71; i >= 8; i--)
      if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
    return v[7:0];
  endfunction

  function automatic logic [7:0] extra_byte(input logic [63:0] d);
`ifdef BB_READOUT_CRC_EN
    return crc_ref(d);
`else
    return (d == d) ? 8'h00 : 8'h00;
`endif
  endfunction

  // Expected 72 bits following the command byte, idle engine (not restarting).
  function automatic logic [71:0] model_tail(input logic [7:0] c, input logic [63:0] d, input logic h);
    logic [7:0] st;
    st = {h, 1'b0, 6'h01};
    if (c == 8'h0B)      return {d, extra_byte(d)};
    else if (c == 8'h05) return {9{st}};
    else                 return 72'h0;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic frame(input logic [7:0] c, input int nbits, output logic [7:0] st, output logic [71:0] tail);
    st   = 8'h00;
    tail = 72'h0;
    @(negedge clk);
    spi_if.cs_n = 1'b0;
    cnt_at_fall = bb_count;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_if.mosi = (i < 8) ? c[7 - i] : 1'b0;
      repeat (8) @(negedge clk);
      if (i < 8) st[7 - i] = spi_if.miso;
      else       tail = {tail[70:0], spi_if.miso};
      spi_if.sclk = 1'b1;
      repeat (8) @(negedge clk);
      spi_if.sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    spi_if.cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [63:0] count;
    logic        halt;
    logic [7:0]  exp_st;
    logic [71:0] exp_tail;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    logic [7:0]  st;
    logic [71:0] tail;
    logic [63:0] rc, diff;
    logic [7:0]  rcmd;
    logic        rh;
    int          p0;

    tbl[0] = '{8'h05, 64'h0000_0000_0000_1234, 1'b0, 8'h01, {9{8'h01}}};
    tbl[1] = '{8'h0B, 64'h0000_0001_A280_6C4D, 1'b1, 8'h81,
               {64'h0000_0001_A280_6C4D, extra_byte(64'h0000_0001_A280_6C4D)}};
    tbl[2] = '{8'h05, 64'h0, 1'b1, 8'h81, {9{8'h81}}};
    tbl[3] = '{8'h33, 64'hDEAD_BEEF_0000_0001, 1'b0, 8'h01, 72'h0};
    tbl[4] = '{8'h0B, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h01,
               {64'hFFFF_FFFF_FFFF_FFFF, extra_byte(64'hFFFF_FFFF_FFFF_FFFF)}};

    spi_if.cs_n = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_miso", {71'h0, spi_if.miso}, 72'h0);
    chk("reset_bb_rst_n", {71'h0, bb_rst_n}, 72'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("bb_rst_n_release", {71'h0, bb_rst_n}, 72'h1);
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      count_base = tbl[i].count;
      bb_halt    = tbl[i].halt;
      frame(tbl[i].cmd, 80, st, tail);
      chk($sformatf("vec%0d_status", i), {64'h0, st}, {64'h0, tbl[i].exp_st});
      chk($sformatf("vec%0d_tail", i), tail, tbl[i].exp_tail);
    end

    for (int i = 0; i < 20; i++) begin
      rc = {$urandom, $urandom};
      rh = 1'($urandom % 2);
      case ($urandom % 3)
        0:       rcmd = 8'h0B;
        1:       rcmd = 8'h05;
        default: begin
          rcmd = 8'($urandom);
          if (rcmd == 8'hA5) rcmd = 8'h00;
        end
      endcase
      count_base = rc;
      bb_halt    = rh;
      frame(rcmd, 80, st, tail);
      chk($sformatf("rand%0d_status", i), {64'h0, st}, {64'h0, rh, 1'b0, 6'h01});
      chk($sformatf("rand%0d_tail_cmd%h", i, rcmd), tail, model_tail(rcmd, rc, rh));
    end

    // Counter running every clk across a 32-bit carry.
    bb_halt    = 1'b0;
    count_base = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    inc_en = 1'b1;
    frame(8'h0B, 80, st, tail);
    inc_en = 1'b0;
    diff = tail[71:8] - cnt_at_fall;
    checks++;
    if (diff > 64'd8) begin
      errors++;
      $display("FAIL inc_snapshot actual=%h expected_near=%h", tail[71:8], cnt_at_fall);
    end
    chk("inc_extra_byte", {64'h0, tail[7:0]}, {64'h0, extra_byte(tail[71:8])});

    // RESTART committed after exactly 8 bits; status read while the pulse is active.
    count_base = 64'h0;
    p0 = pulses;
    frame(8'hA5, 8, st, tail);
    frame(8'h00, 8, st, tail);
    chk("busy_status", {64'h0, st}, 72'h41);
    repeat (30) @(negedge clk);
    chk("restart_pulse_count", 72'(pulses - p0), 72'd1);
    chk("restart_pulse_width", 72'(last_width), 72'd16);

    // Ninth SCLK rise cancels the restart.
    p0 = pulses;
    frame(8'hA5, 9, st, tail);
    repeat (40) @(negedge clk);
    chk("restart_cancel", 72'(pulses - p0), 72'd0);
    chk("restart_cancel_rst_high", {71'h0, bb_rst_n}, 72'h1);

    // Aborted READ_COUNT followed by a complete one.
    bb_halt    = 1'b1;
    count_base = 64'h0123_4567_89AB_CDEF;
    frame(8'h0B, 20, st, tail);
    count_base = 64'h0000_0001_A280_6C4D;
    frame(8'h0B, 80, st, tail);
    chk("abort_next_status", {64'h0, st}, 72'h81);
    chk("abort_next_tail", tail, {64'h0000_0001_A280_6C4D, extra_byte(64'h0000_0001_A280_6C4D)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
